// File: rtl/freefall_seq_ctrl.sv
// freefall_seq_ctrl: per-frame jump/fall sequencer for the player sprite.
// Holds the player's height and vertical velocity, drives the external
// registered FreeFall unit (y' = y + v - 7, v' = v - 14) and applies ground
// landing, ceiling bonk, bottom fall-off and terminal-velocity clamping.
// Optional feature: define DOUBLE_JUMP_EN to allow one extra jump while airborne.

module freefall_seq_ctrl #(
  parameter logic [8:0] Y_MAX  = 9'd200,
  parameter logic [8:0] JUMP_V = 9'd48,
  parameter logic [8:0] V_MAX  = 9'd56
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick_i,
  input  logic       jump_req_i,
  input  logic       support_i,
  input  logic [8:0] ground_y_i,
  output logic [8:0] ff_y_init_o,
  output logic [8:0] ff_v_init_o,
  input  logic [8:0] ff_y_i,
  input  logic [8:0] ff_v_i,
  output logic [8:0] pos_y_o,
  output logic [8:0] vel_o,
  output logic       airborne_o,
  output logic       landed_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    ST_GROUND  = 2'd0,
    ST_AIR     = 2'd1,
    ST_STEP    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  state_t     state_q;
  logic [8:0] pos_y_q;
  logic [8:0] vel_q;
  logic       airborne_q;
  logic       landed_q;
  logic       busy_q;
  logic       jump_pend_q;
`ifdef DOUBLE_JUMP_EN
  logic       air_jump_used_q;
`endif

  // Signed views of the FreeFall result and the collision thresholds.
  logic signed [8:0] ff_y_s;
  logic signed [8:0] ff_v_s;
  logic signed [8:0] ground_s;
  logic signed [8:0] neg_vmax_s;
  logic signed [8:0] v_clamp_s;
  logic              land_hit_s;
  logic              ceil_hit_s;
  logic              under_hit_s;
  logic              jump_now_s;
  logic              tick_open_s;

  assign ff_y_s     = $signed(ff_y_i);
  assign ff_v_s     = $signed(ff_v_i);
  assign ground_s   = $signed(ground_y_i);
  assign neg_vmax_s = 9'sd0 - $signed(V_MAX);

  // Falling through the floor this step while standing-capable ground is present.
  assign land_hit_s  = support_i && (ff_v_s < 9'sd0) && (ff_y_s <= ground_s);
  assign ceil_hit_s  = ff_y_s > $signed(Y_MAX);
  assign under_hit_s = ff_y_s < 9'sd0;
  assign v_clamp_s   = (ff_v_s < neg_vmax_s) ? neg_vmax_s : ff_v_s;

  // A pulse coincident with the tick counts for that tick.
  assign jump_now_s  = jump_pend_q | jump_req_i;
  // Ticks are only accepted while waiting for a frame, never mid-step.
  assign tick_open_s = frame_tick_i && ((state_q == ST_GROUND) || (state_q == ST_AIR));

  assign ff_y_init_o = pos_y_q;
  assign ff_v_init_o = vel_q;
  assign pos_y_o     = pos_y_q;
  assign vel_o       = vel_q;
  assign airborne_o  = airborne_q;
  assign landed_o    = landed_q;
  assign busy_o      = busy_q;

  // Sequencer FSM with registered status outputs and the jump request latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_GROUND;
      pos_y_q         <= 9'd0;
      vel_q           <= 9'd0;
      airborne_q      <= 1'b0;
      landed_q        <= 1'b0;
      busy_q          <= 1'b0;
      jump_pend_q     <= 1'b0;
`ifdef DOUBLE_JUMP_EN
      air_jump_used_q <= 1'b0;
`endif
    end else begin
      landed_q <= 1'b0;
      case (state_q)
        ST_GROUND: begin
          if (frame_tick_i) begin
            if (jump_now_s) begin
              vel_q      <= JUMP_V;
              pos_y_q    <= ground_y_i;
              state_q    <= ST_AIR;
              airborne_q <= 1'b1;
            end else if (!support_i) begin
              vel_q      <= 9'd0;
              state_q    <= ST_AIR;
              airborne_q <= 1'b1;
            end else begin
              pos_y_q    <= ground_y_i;
              vel_q      <= 9'd0;
            end
          end
        end
        ST_AIR: begin
          if (frame_tick_i) begin
            state_q <= ST_STEP;
            busy_q  <= 1'b1;
`ifdef DOUBLE_JUMP_EN
            // One mid-air relaunch; STEP then integrates the new velocity.
            if (jump_now_s && !air_jump_used_q) begin
              vel_q           <= JUMP_V;
              air_jump_used_q <= 1'b1;
            end
`endif
          end
        end
        ST_STEP: begin
          // FreeFall samples pos_y/vel at the end of this cycle.
          state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          busy_q <= 1'b0;
          if (land_hit_s) begin
            pos_y_q    <= ground_y_i;
            vel_q      <= 9'd0;
            landed_q   <= 1'b1;
            airborne_q <= 1'b0;
            state_q    <= ST_GROUND;
`ifdef DOUBLE_JUMP_EN
            air_jump_used_q <= 1'b0;
`endif
          end else if (ceil_hit_s) begin
            pos_y_q <= Y_MAX;
            vel_q   <= 9'd0;
            state_q <= ST_AIR;
          end else if (under_hit_s) begin
            pos_y_q    <= 9'd0;
            vel_q      <= 9'd0;
            landed_q   <= 1'b1;
            airborne_q <= 1'b0;
            state_q    <= ST_GROUND;
`ifdef DOUBLE_JUMP_EN
            air_jump_used_q <= 1'b0;
`endif
          end else begin
            pos_y_q <= ff_y_i;
            vel_q   <= v_clamp_s;
            state_q <= ST_AIR;
          end
        end
        default: begin
          state_q    <= ST_GROUND;
          airborne_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase

      // Pending jump is consumed (or discarded) by every accepted tick.
      if (tick_open_s) begin
        jump_pend_q <= 1'b0;
      end else if (jump_req_i) begin
        jump_pend_q <= 1'b1;
      end else begin
        jump_pend_q <= jump_pend_q;
      end
    end
  end

endmodule

// File: tb/tb_freefall_seq_ctrl.sv
// Directed bench for freefall_seq_ctrl with a behavioural FreeFall unit.
module tb_freefall_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       jump_req;
  logic       support;
  logic [8:0] ground_y;
  logic [8:0] ff_y_init;
  logic [8:0] ff_v_init;
  logic [8:0] ff_y;
  logic [8:0] ff_v;
  logic [8:0] pos_y;
  logic [8:0] vel;
  logic       airborne;
  logic       landed;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  freefall_seq_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick_i(frame_tick),
    .jump_req_i  (jump_req),
    .support_i   (support),
    .ground_y_i  (ground_y),
    .ff_y_init_o (ff_y_init),
    .ff_v_init_o (ff_v_init),
    .ff_y_i      (ff_y),
    .ff_v_i      (ff_v),
    .pos_y_o     (pos_y),
    .vel_o       (vel),
    .airborne_o  (airborne),
    .landed_o    (landed),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered FreeFall unit shared with the sequencer.
  always_ff @(posedge clk) begin
    ff_y <= ff_y_init + ff_v_init - 9'd7;
    ff_v <= ff_v_init - 9'd14;
  end

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, $signed(got), got,
               $signed(exp), exp);
    end
  endtask

  task automatic check_pv(input string tag, input logic [8:0] ey, input logic [8:0] ev);
    check({tag, ".pos_y"}, pos_y, ey);
    check({tag, ".vel"}, vel, ev);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    jump_req   = 1'b0;
    support    = 1'b1;
    ground_y   = 9'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One frame tick; returns at the negedge after the step result has landed.
  task automatic do_tick(input logic jr);
    @(negedge clk);
    frame_tick = 1'b1;
    jump_req   = jr;
    @(negedge clk);
    frame_tick = 1'b0;
    jump_req   = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Scenario 1: reset values, then a pending-jump launch from ground 0.
    do_reset();
    check("rst.pos_y", pos_y, 9'd0);
    check("rst.vel", vel, 9'd0);
    check("rst.airborne", {8'd0, airborne}, 9'd0);
    check("rst.landed", {8'd0, landed}, 9'd0);
    check("rst.busy", {8'd0, busy}, 9'd0);
    check("rst.ff_y_init", ff_y_init, 9'd0);
    @(negedge clk);
    jump_req = 1'b1;
    @(negedge clk);
    jump_req = 1'b0;
    do_tick(1'b0);
    check_pv("s1.launch", 9'd0, 9'd48);
    check("s1.airborne", {8'd0, airborne}, 9'd1);
    check("s1.ff_v_init", ff_v_init, 9'd48);
    do_tick(1'b0); check_pv("s1.t2", 9'd41, 9'd34);
    check("s1.busy_idle", {8'd0, busy}, 9'd0);
    do_tick(1'b0); check_pv("s1.t3", 9'd68, 9'd20);
    do_tick(1'b0); check_pv("s1.t4", 9'd81, 9'd6);
    do_tick(1'b0); check_pv("s1.t5", 9'd80, -9'sd8);
    do_tick(1'b0); check_pv("s1.t6", 9'd65, -9'sd22);
    do_tick(1'b0); check_pv("s1.t7", 9'd36, -9'sd36);
    do_tick(1'b0); check_pv("s1.land", 9'd0, 9'd0);
    check("s1.landed", {8'd0, landed}, 9'd1);
    check("s1.airborne_0", {8'd0, airborne}, 9'd0);
    @(negedge clk);
    check("s1.landed_pulse", {8'd0, landed}, 9'd0);

    // Scenarios 2/3: ceiling bonk from ground 190, long fall with clamp, landing.
    do_reset();
    ground_y = 9'd190;
    do_tick(1'b0); check_pv("s3.stand", 9'd190, 9'd0);
    check("s3.ground_airborne", {8'd0, airborne}, 9'd0);
    do_tick(1'b1); check_pv("s3.launch", 9'd190, 9'd48);
    do_tick(1'b0); check_pv("s3.bonk", 9'd200, 9'd0);
    check("s3.bonk_airborne", {8'd0, airborne}, 9'd1);
    do_tick(1'b0); check_pv("s3.after_bonk", 9'd193, -9'sd14);
    ground_y = 9'd0;
    do_tick(1'b0); check_pv("s2.f1", 9'd172, -9'sd28);
    do_tick(1'b0); check_pv("s2.f2", 9'd137, -9'sd42);
    do_tick(1'b0); check_pv("s2.f3", 9'd88, -9'sd56);
    do_tick(1'b0); check_pv("s2.clamp", 9'd25, -9'sd56);
    do_tick(1'b0); check_pv("s2.land", 9'd0, 9'd0);
    check("s2.landed", {8'd0, landed}, 9'd1);
    check("s2.airborne_0", {8'd0, airborne}, 9'd0);
    @(negedge clk);
    check("s2.landed_pulse", {8'd0, landed}, 9'd0);

    // Scenario 4: walk off a ledge at 50, fall off the bottom without support.
    do_reset();
    ground_y = 9'd50;
    do_tick(1'b0); check_pv("s4.stand", 9'd50, 9'd0);
    support  = 1'b0;
    ground_y = 9'd0;
    do_tick(1'b0); check_pv("s4.walkoff", 9'd50, 9'd0);
    check("s4.airborne", {8'd0, airborne}, 9'd1);
    do_tick(1'b0); check_pv("s4.f1", 9'd43, -9'sd14);
    do_tick(1'b0); check_pv("s4.f2", 9'd22, -9'sd28);
    do_tick(1'b0); check_pv("s4.bottom", 9'd0, 9'd0);
    check("s4.landed", {8'd0, landed}, 9'd1);
    check("s4.airborne_0", {8'd0, airborne}, 9'd0);

    // Scenario 5: tick held through STEP/CAPTURE is ignored; reset mid-capture.
    do_reset();
    do_tick(1'b1); check_pv("s5.launch", 9'd0, 9'd48);
    @(negedge clk);
    frame_tick = 1'b1;
    repeat (3) @(negedge clk);
    frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    check_pv("s5.one_step", 9'd41, 9'd34);
    check("s5.busy_idle", {8'd0, busy}, 9'd0);
    do_tick(1'b0); check_pv("s5.no_backlog", 9'd68, 9'd20);
    @(negedge clk);
    frame_tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    frame_tick = 1'b0;
    check("s5.busy_step", {8'd0, busy}, 9'd1);
    @(posedge clk);
    #2;
    check("s5.busy_capture", {8'd0, busy}, 9'd1);
    rst_n = 1'b0;
    #1;
    check("s5.arst.pos_y", pos_y, 9'd0);
    check("s5.arst.vel", vel, 9'd0);
    check("s5.arst.airborne", {8'd0, airborne}, 9'd0);
    check("s5.arst.busy", {8'd0, busy}, 9'd0);
    check("s5.arst.landed", {8'd0, landed}, 9'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_pv("s5.after_rst", 9'd0, 9'd0);

    // Scenario 6: jump at the apex, then a third jump request.
    do_reset();
    do_tick(1'b1); check_pv("s6.launch", 9'd0, 9'd48);
    do_tick(1'b0); check_pv("s6.t2", 9'd41, 9'd34);
    do_tick(1'b0); check_pv("s6.t3", 9'd68, 9'd20);
    do_tick(1'b0); check_pv("s6.apex", 9'd81, 9'd6);
`ifdef DOUBLE_JUMP_EN
    do_tick(1'b1); check_pv("s6.air_jump", 9'd122, 9'd34);
    do_tick(1'b1); check_pv("s6.third_ignored", 9'd149, 9'd20);
    do_tick(1'b0); check_pv("s6.pend_cleared", 9'd162, 9'd6);
`else
    do_tick(1'b1); check_pv("s6.air_jump", 9'd80, -9'sd8);
    do_tick(1'b1); check_pv("s6.third_ignored", 9'd65, -9'sd22);
    do_tick(1'b0); check_pv("s6.pend_cleared", 9'd36, -9'sd36);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
